mcsr_vec: RTL

- Parametrised next-generation machine CSR file for the vanilla core.
- Handles num_irq_p maskable interrupt sources with fixed priority selection.
- Adds mtvec with direct/vectored mode, mcause, and 64-bit-capable mcycle/minstret counters.
- Sits between ID/EXE: CSR instructions update it on ID->EXE; EXE signals interrupt entry and mret.

---
 rtl/mcsr_vec.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mcsr_vec.sv
// Machine CSR file: mstatus/mie/mip/mtvec/mepc/mcause plus mcycle/minstret counters,
// with fixed-priority interrupt selection and direct/vectored trap targets.
module mcsr_vec #(
    parameter int pc_width_p      = 22,
    parameter int num_irq_p       = 4,
    parameter int counter_width_p = 64,
    parameter int lg_irq_lp       = (num_irq_p > 1) ? $clog2(num_irq_p) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       we_i,
    input  logic [11:0]                addr_i,
    input  logic [2:0]                 funct3_i,
    input  logic [31:0]                data_i,
    input  logic [4:0]                 rs1_i,
    output logic [31:0]                data_o,
    input  logic [num_irq_p-1:0]       irq_set_i,
    input  logic [num_irq_p-1:0]       irq_clear_i,
    input  logic                       instr_retired_i,
    input  logic                       interrupt_entered_i,
    input  logic                       mret_called_i,
    input  logic [pc_width_p-1:0]      npc_r_i,
    output logic                       interrupt_pending_o,
    output logic [lg_irq_lp-1:0]       interrupt_id_o,
    output logic [pc_width_p-1:0]      mtvec_target_o,
    output logic                       mstatus_mie_o,
    output logic [pc_width_p-1:0]      mepc_r_o
);

    localparam int hi_w_lp = counter_width_p - 32;

    logic                       mstatus_mie_r, mstatus_mpie_r;
    logic [num_irq_p-1:0]       mie_r, mip_r, irq_act;
    logic [pc_width_p-1:0]      mtvec_base_r, mepc_r;
    logic                       mtvec_mode_r;
    logic                       mcause_int_r;
    logic [4:0]                 mcause_code_r;
    logic [counter_width_p-1:0] mcycle_r, minstret_r;

    logic [31:0]          op, rd_data, csr_new;
    logic                 csr_wr;
    logic                 wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause, wr_mip;
    logic                 wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;
    logic [lg_irq_lp-1:0] irq_id;
    logic [num_irq_p-1:0] mip_wr_val;

    assign op     = funct3_i[2] ? {27'b0, rs1_i} : data_i;
    assign csr_wr = we_i && (funct3_i[1:0] != 2'b00);

    always_comb begin
        rd_data = '0;
        case (addr_i)
            12'h300: rd_data = {24'b0, mstatus_mpie_r, 3'b0, mstatus_mie_r, 3'b0};
            12'h304: rd_data = 32'(mie_r) << 16;
            12'h305: rd_data = (32'(mtvec_base_r) << 2) | {31'b0, mtvec_mode_r};
            12'h341: rd_data = 32'(mepc_r) << 2;
            12'h342: rd_data = {mcause_int_r, 26'b0, mcause_code_r};
            12'h344: rd_data = 32'(mip_r) << 16;
            12'hB00: rd_data = mcycle_r[31:0];
            12'hB02: rd_data = minstret_r[31:0];
            12'hB80: rd_data = 32'(mcycle_r[counter_width_p-1:32]);
            12'hB82: rd_data = 32'(minstret_r[counter_width_p-1:32]);
            default: rd_data = '0;
        endcase
    end

    assign data_o = rd_data;

    // Read-modify-write ops act on the visible (masked) register image.
    always_comb begin
        case (funct3_i[1:0])
            2'b01:   csr_new = op;
            2'b10:   csr_new = rd_data | op;
            default: csr_new = rd_data & ~op;
        endcase
    end

    assign wr_mstatus = csr_wr && (addr_i == 12'h300);
    assign wr_mie     = csr_wr && (addr_i == 12'h304);
    assign wr_mtvec   = csr_wr && (addr_i == 12'h305);
    assign wr_mepc    = csr_wr && (addr_i == 12'h341);
    assign wr_mcause  = csr_wr && (addr_i == 12'h342);
    assign wr_mip     = csr_wr && (addr_i == 12'h344);
    assign wr_cyc_lo  = csr_wr && (addr_i == 12'hB00);
    assign wr_cyc_hi  = csr_wr && (addr_i == 12'hB80);
    assign wr_ins_lo  = csr_wr && (addr_i == 12'hB02);
    assign wr_ins_hi  = csr_wr && (addr_i == 12'hB82);

    assign irq_act = mip_r & mie_r;

    always_comb begin
        irq_id = '0;
        for (int i = 0; i < num_irq_p; i++) begin
            if (irq_act[i]) irq_id = lg_irq_lp'(i);
        end
    end

    assign interrupt_pending_o = mstatus_mie_r && (|irq_act);
    assign interrupt_id_o      = irq_id;
    assign mtvec_target_o      = mtvec_mode_r ? (mtvec_base_r + pc_width_p'(irq_id)) : mtvec_base_r;
    assign mstatus_mie_o       = mstatus_mie_r;
    assign mepc_r_o            = mepc_r;

    assign mip_wr_val = wr_mip ? csr_new[16 +: num_irq_p] : mip_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
            mie_r          <= '0;
            mip_r          <= '0;
            mtvec_base_r   <= '0;
            mtvec_mode_r   <= 1'b0;
            mepc_r         <= '0;
            mcause_int_r   <= 1'b0;
            mcause_code_r  <= '0;
        end else begin
            // mret outranks entry, and both outrank a CSR write to mstatus.
            if (mret_called_i) begin
                mstatus_mie_r  <= mstatus_mpie_r;
                mstatus_mpie_r <= 1'b0;
            end else if (interrupt_entered_i) begin
                mstatus_mpie_r <= mstatus_mie_r;
                mstatus_mie_r  <= 1'b0;
            end else if (wr_mstatus) begin
                mstatus_mie_r  <= csr_new[3];
                mstatus_mpie_r <= csr_new[7];
            end

            if (wr_mie) mie_r <= csr_new[16 +: num_irq_p];

            mip_r <= (mip_wr_val & ~irq_clear_i) | irq_set_i;

            if (wr_mtvec) begin
                mtvec_base_r <= csr_new[2 +: pc_width_p];
                mtvec_mode_r <= csr_new[0];
            end

            if (interrupt_entered_i) begin
                mepc_r        <= npc_r_i;
                mcause_int_r  <= 1'b1;
                mcause_code_r <= 5'(irq_id) + 5'd16;
            end else begin
                if (wr_mepc) mepc_r <= csr_new[2 +: pc_width_p];
                if (wr_mcause) begin
                    mcause_int_r  <= csr_new[31];
                    mcause_code_r <= csr_new[4:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mcycle_r   <= '0;
            minstret_r <= '0;
        end else begin
            if (wr_cyc_lo)      mcycle_r[31:0] <= csr_new;
            else if (wr_cyc_hi) mcycle_r[counter_width_p-1:32] <= csr_new[hi_w_lp-1:0];
            else                mcycle_r <= mcycle_r + counter_width_p'(1);

            if (wr_ins_lo)            minstret_r[31:0] <= csr_new;
            else if (wr_ins_hi)       minstret_r[counter_width_p-1:32] <= csr_new[hi_w_lp-1:0];
            else if (instr_retired_i) minstret_r <= minstret_r + counter_width_p'(1);
        end
    end

endmodule
